// File: rtl/scu_pkg.sv
// Shared types and helpers for the stochastic-to-binary conversion blocks.
package scu_pkg;

  localparam int unsigned DATAWD_DEF = 8;

  typedef enum logic [1:0] {S2B_IDLE, S2B_ACCUM, S2B_HOLD} s2b_state_t;

  // Scale a window ones-count down to datawd bits; a full window (2**winlog) clips to all-ones.
  // Assumes winlog >= datawd and datawd < 32.
  function automatic logic [31:0] sat_scale(input logic [31:0] cnt,
                                            input int unsigned winlog,
                                            input int unsigned datawd);
    logic [31:0] scaled;
    logic [31:0] maxv;
    scaled = cnt >> (winlog - datawd);
    maxv   = (32'd1 << datawd) - 32'd1;
    return (scaled > maxv) ? maxv : scaled;
  endfunction

endpackage

// File: rtl/s2b_ones_cnt.sv
// Per-channel ones counter for one stochastic stream.
module s2b_ones_cnt #(
  parameter int unsigned CntW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            bit_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CntW'(bit_i);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/s2b_pair_counter.sv
// Lockstep stochastic-to-binary converter for a pair of streams with valid/ready output.
module s2b_pair_counter
  import scu_pkg::*;
#(
  parameter int unsigned DATAWD = DATAWD_DEF,
  parameter int unsigned WINLOG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iStart,
  input  logic              iEn,
  input  logic              iBitA,
  input  logic              iBitB,
  input  logic              iReady,
  output logic [DATAWD-1:0] oA,
  output logic [DATAWD-1:0] oB,
  output logic              oValid,
  output logic              oBusy
);

  localparam logic [WINLOG-1:0] WinLast = '1;

  s2b_state_t        state_q;
  logic [WINLOG-1:0] win_q;
  logic [DATAWD-1:0] a_q, b_q;
  logic              valid_q, busy_q;
  logic [WINLOG:0]   cnt_a, cnt_b;
  logic [WINLOG:0]   fin_a, fin_b;
  logic              cnt_clr, cnt_en;

  // Counters clear on entry to ACCUM, from IDLE or straight out of a HOLD handshake.
  assign cnt_clr = iStart && ((state_q == S2B_IDLE) || ((state_q == S2B_HOLD) && iReady));
  assign cnt_en  = (state_q == S2B_ACCUM) && iEn;

  // The last enabled cycle's bits must be folded into the registered result.
  assign fin_a = cnt_a + (WINLOG+1)'(iBitA);
  assign fin_b = cnt_b + (WINLOG+1)'(iBitB);

  s2b_ones_cnt #(.CntW(WINLOG + 1)) u_cnt_a (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .bit_i (iBitA),
    .cnt_o (cnt_a)
  );

  s2b_ones_cnt #(.CntW(WINLOG + 1)) u_cnt_b (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .bit_i (iBitB),
    .cnt_o (cnt_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S2B_IDLE;
      win_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S2B_IDLE: begin
          if (iStart) begin
            state_q <= S2B_ACCUM;
            win_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S2B_ACCUM: begin
          if (iEn) begin
            win_q <= win_q + WINLOG'(1);
            if (win_q == WinLast) begin
              a_q     <= DATAWD'(sat_scale(32'(fin_a), WINLOG, DATAWD));
              b_q     <= DATAWD'(sat_scale(32'(fin_b), WINLOG, DATAWD));
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S2B_HOLD;
            end
          end
        end
        S2B_HOLD: begin
          if (iReady) begin
            valid_q <= 1'b0;
            if (iStart) begin
              state_q <= S2B_ACCUM;
              win_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S2B_IDLE;
            end
          end
        end
        default: state_q <= S2B_IDLE;
      endcase
    end
  end

  assign oA     = a_q;
  assign oB     = b_q;
  assign oValid = valid_q;
  assign oBusy  = busy_q;

endmodule

// File: tb/tb_s2b_pair_counter.sv
// Randomized self-checking bench for s2b_pair_counter against a window-sum reference model.
module tb_s2b_pair_counter;

  logic       clk = 1'b0;
  logic       rst, iStart, start10, iEn, iBitA, iBitB, iReady;
  logic [7:0] oA, oB, oA10, oB10;
  logic       oValid, oBusy, oValid10, oBusy10;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  s2b_pair_counter #(.DATAWD(8), .WINLOG(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .iStart (iStart),
    .iEn    (iEn),
    .iBitA  (iBitA),
    .iBitB  (iBitB),
    .iReady (iReady),
    .oA     (oA),
    .oB     (oB),
    .oValid (oValid),
    .oBusy  (oBusy)
  );

  s2b_pair_counter #(.DATAWD(8), .WINLOG(10)) dut10 (
    .clk    (clk),
    .rst    (rst),
    .iStart (start10),
    .iEn    (iEn),
    .iBitA  (iBitA),
    .iBitB  (iBitB),
    .iReady (iReady),
    .oA     (oA10),
    .oB     (oB10),
    .oValid (oValid10),
    .oBusy  (oBusy10)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: ones over the enabled bits, dropped to 8 bits, clipped at 255.
  function automatic int ref_val(input int ones, input int winlog);
    int v;
    v = ones / (1 << (winlog - 8));
    return (v > 255) ? 255 : v;
  endfunction

  // mode 0 random (+ stray iStart), 1 A=1/B=0, 2 A alt/B every 4th, 3 all ones, 4 A alt/B random
  task automatic run_window(input bit sel10, input bit do_start, input int mode, input bit gaps,
                            output int ea, output int eb);
    int winlen = sel10 ? 1024 : 256;
    int winlog = sel10 ? 10 : 8;
    int ca = 0, cb = 0, seen = 0, cyc = 0;
    bit a, b, e;
    if (do_start) begin
      @(negedge clk);
      iEn = 1'b0;
      if (sel10) start10 = 1'b1; else iStart = 1'b1;
      @(negedge clk);
      iStart  = 1'b0;
      start10 = 1'b0;
    end
    iReady = 1'b0;
    check_eq("busy_start", sel10 ? oBusy10 : oBusy, 1);
    while (seen < winlen) begin
      if (cyc > 0) @(negedge clk);
      if (gaps) e = (cyc % 3) != 2;
      else      e = 1'b1;
      case (mode)
        1:       begin a = 1'b1;              b = 1'b0;              end
        2:       begin a = (seen % 2) == 0;   b = (seen % 4) == 0;   end
        3:       begin a = 1'b1;              b = 1'b1;              end
        4:       begin a = (seen % 2) == 0;   b = 1'($urandom_range(1)); end
        default: begin a = 1'($urandom_range(1)); b = ($urandom_range(3) == 0); end
      endcase
      if (!e) begin a = 1'b1; b = 1'b1; end
      if (mode == 0 && !sel10) iStart = 1'($urandom_range(1));
      if (e && seen == winlen - 1) check_eq("valid_early", sel10 ? oValid10 : oValid, 0);
      iEn = e; iBitA = a; iBitB = b;
      if (e) begin
        ca += int'(a);
        cb += int'(b);
        seen++;
      end
      cyc++;
    end
    @(negedge clk);
    iEn = 1'b0; iBitA = 1'b0; iBitB = 1'b0; iStart = 1'b0;
    ea = ref_val(ca, winlog);
    eb = ref_val(cb, winlog);
    check_eq("valid_rise", sel10 ? oValid10 : oValid, 1);
    check_eq("busy_done", sel10 ? oBusy10 : oBusy, 0);
    check_eq("oA", sel10 ? oA10 : oA, ea);
    check_eq("oB", sel10 ? oB10 : oB, eb);
  endtask

  task automatic ack(input bit sel10);
    @(negedge clk);
    iReady = 1'b1;
    @(negedge clk);
    iReady = 1'b0;
    check_eq("valid_drop", sel10 ? oValid10 : oValid, 0);
    check_eq("busy_idle", sel10 ? oBusy10 : oBusy, 0);
  endtask

  initial begin
    int ea, eb, pa;
    rst = 1'b1; iStart = 1'b0; start10 = 1'b0; iEn = 1'b0;
    iBitA = 1'b0; iBitB = 1'b0; iReady = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_oA", oA, 0);
    check_eq("rst_oB", oB, 0);
    check_eq("rst_valid", oValid, 0);
    check_eq("rst_busy", oBusy, 0);
    rst = 1'b0;

    // Enabled bits while idle must not reach the counters
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iEn = 1'b1; iBitA = 1'b1; iBitB = 1'b1;
      check_eq("idle_busy", oBusy, 0);
    end

    run_window(0, 1, 1, 0, ea, eb);
    ack(0);

    run_window(0, 1, 2, 0, ea, eb);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("hold_valid", oValid, 1);
      check_eq("hold_oA", oA, ea);
      check_eq("hold_oB", oB, eb);
    end
    ack(0);
    check_eq("keep_oA", oA, ea);

    run_window(0, 1, 2, 1, ea, eb);
    ack(0);

    for (int i = 0; i < 3; i++) begin
      run_window(0, 1, 0, 1'($urandom_range(1)), ea, eb);
      ack(0);
    end

    // Back-to-back: handshake and restart on the same edge
    run_window(0, 1, 0, 0, ea, eb);
    pa = ea;
    @(negedge clk);
    iReady = 1'b1; iStart = 1'b1;
    @(negedge clk);
    iReady = 1'b0; iStart = 1'b0;
    check_eq("b2b_valid", oValid, 0);
    check_eq("b2b_keep_oA", oA, pa);
    run_window(0, 0, 4, 1, ea, eb);
    ack(0);

    // Reset at enabled cycle 100 of a window
    @(negedge clk);
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    for (int i = 0; i < 100; i++) begin
      iEn = 1'b1; iBitA = 1'b1; iBitB = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; iEn = 1'b0;
    check_eq("mid_rst_oA", oA, 0);
    check_eq("mid_rst_oB", oB, 0);
    check_eq("mid_rst_valid", oValid, 0);
    check_eq("mid_rst_busy", oBusy, 0);
    run_window(0, 1, 3, 0, ea, eb);
    ack(0);

    run_window(1, 1, 4, 0, ea, eb);
    ack(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
